bcd_to_bin: RTL and testbench

//  Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock).

---
 rtl/bcd_pkg.sv | 10 +
 rtl/bcd_dig_corr.sv | 11 +
 rtl/bcd_to_bin.sv | 111 +++++++++++
 tb/tb_bcd_to_bin.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD-to-binary converter
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_CORR = 4'd3;

endpackage

// File: rtl/bcd_dig_corr.sv
// rtl/bcd_dig_corr.sv - per-digit correction step of reverse double-dabble
module bcd_dig_corr
  import bcd_pkg::*;
(
  input  bcd_digit_t d_in,
  output bcd_digit_t d_out
);

  assign d_out = (d_in >= 4'd8) ? d_in - BCD_CORR : d_in;

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential BCD-to-binary converter, one shift per clock
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 2,
  parameter int OUT_W   = 7,
  parameter int MAX_VAL = 59
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NDIGITS-1:0] bcd_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     bin_out,
  output logic                 err_digit,
  output logic                 err_range
);

  localparam int W     = 4 * NDIGITS;
  localparam int CNT_W = $clog2(W);

  bcd_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     bcd_q;
  logic [W-1:0]     bin_q;
  logic [OUT_W-1:0] bin_out_q;
  logic             err_digit_q;
  logic             err_range_q;

  logic [2*W-1:0]   shifted;
  logic [W-1:0]     bcd_d;
  logic [W-1:0]     bin_d;
  logic [OUT_W-1:0] bin_trunc;
  logic             digit_bad;
  logic             range_bad;

  assign shifted = {bcd_q, bin_q} >> 1;
  assign bin_d   = shifted[W-1:0];

  for (genvar g = 0; g < NDIGITS; g++) begin : g_corr
    bcd_dig_corr u_corr (
      .d_in  (shifted[W + 4*g +: 4]),
      .d_out (bcd_d[4*g +: 4])
    );
  end

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  // Range check sees the full internal width, before truncation to OUT_W.
  assign range_bad = $unsigned(32'(bin_d)) > $unsigned(32'(MAX_VAL));
  assign bin_trunc = OUT_W'(bin_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bcd_q       <= '0;
      bin_q       <= '0;
      bin_out_q   <= '0;
      err_digit_q <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (digit_bad) begin
              state_q     <= DONE;
              bin_out_q   <= '0;
              err_digit_q <= 1'b1;
              err_range_q <= 1'b0;
            end else begin
              state_q <= SHIFT;
              bcd_q   <= bcd_in;
              bin_q   <= '0;
              cnt_q   <= CNT_W'(W - 1);
            end
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q     <= DONE;
            bin_out_q   <= bin_trunc;
            err_digit_q <= 1'b0;
            err_range_q <= range_bad;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bin_out   = bin_out_q;
  assign err_digit = err_digit_q;
  assign err_range = err_range_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - scoreboard bench for bcd_to_bin
module tb_bcd_to_bin;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] bcd_in;
  logic [6:0] bin_out;
  logic       err_digit, err_range;

  logic       in_valid9, in_ready9, out_valid9, out_ready9;
  logic [7:0] bcd_in9;
  logic [6:0] bin_out9;
  logic       err_digit9, err_range9;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] bin;
    logic       ed;
    logic       er;
    int         lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_to_bin #(.NDIGITS(2), .OUT_W(7), .MAX_VAL(59)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .bcd_in(bcd_in), .out_valid(out_valid), .out_ready(out_ready),
    .bin_out(bin_out), .err_digit(err_digit), .err_range(err_range)
  );

  bcd_to_bin #(.NDIGITS(2), .OUT_W(7), .MAX_VAL(99)) dut99 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid9), .in_ready(in_ready9),
    .bcd_in(bcd_in9), .out_valid(out_valid9), .out_ready(out_ready9),
    .bin_out(bin_out9), .err_digit(err_digit9), .err_range(err_range9)
  );

  function automatic exp_t model(input logic [7:0] b, input int maxv);
    exp_t e;
    int   v;
    if (b[3:0] > 4'd9 || b[7:4] > 4'd9) begin
      e.bin = 7'd0; e.ed = 1'b1; e.er = 1'b0; e.lat = 1;
    end else begin
      v = int'(b[7:4]) * 10 + int'(b[3:0]);
      e.bin = 7'(v); e.ed = 1'b0; e.er = (v > maxv); e.lat = 9;
    end
    return e;
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bcd_in   = b;
    in_valid = 1'b1;
    sb.push_back(model(b, 59));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    bcd_in   = 8'hFF;
  endtask

  task automatic collect(input string name);
    exp_t e;
    int   n = 1;
    bit   busy_bad = 1'b0;
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s_queue: got empty scoreboard, required one entry", name);
      return;
    end
    e = sb.pop_front();
    while (!out_valid && n < 40) begin
      if (in_ready !== 1'b0) busy_bad = 1'b1;
      @(posedge clk); n++;
      @(negedge clk);
    end
    checks++;
    if (n !== e.lat || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges (out_valid=%b), required %0d", name, n, out_valid, e.lat);
    end
    checks++;
    if (bin_out !== e.bin) begin
      errors++; $display("FAIL %s_bin: got %0d, required %0d", name, bin_out, e.bin);
    end
    checks++;
    if (err_digit !== e.ed || err_range !== e.er) begin
      errors++;
      $display("FAIL %s_flags: got ed=%b er=%b, required ed=%b er=%b", name, err_digit, err_range, e.ed, e.er);
    end
    checks++;
    if (busy_bad) begin
      errors++; $display("FAIL %s_in_ready_busy: got 1 during conversion, required 0", name);
    end
    if (out_ready) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s_release: got out_valid=%b in_ready=%b, required 0/1", name, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== 7'd0 ||
        err_digit !== 1'b0 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b bin=%0d ed=%b er=%b, required 1 0 0 0 0",
               in_ready, out_valid, bin_out, err_digit, err_range);
    end
    checks++;
    if (in_ready9 !== 1'b1 || out_valid9 !== 1'b0 || bin_out9 !== 7'd0) begin
      errors++;
      $display("FAIL reset99: got rdy=%b vld=%b bin=%0d, required 1 0 0", in_ready9, out_valid9, bin_out9);
    end
  endtask

  task automatic test_basic();
    send(8'h59); collect("conv59");
    send(8'h00); collect("conv00");
    send(8'h10); collect("conv10");
    send(8'h87); collect("conv87");
  endtask

  task automatic test_digit_err();
    send(8'h5A); collect("digit_5A");
    send(8'hA5); collect("digit_A5");
  endtask

  task automatic test_range();
    exp_t e;
    int   n = 0;
    send(8'h60); collect("range60");
    e = model(8'h99, 99);
    @(negedge clk);
    bcd_in9   = 8'h99;
    in_valid9 = 1'b1;
    @(posedge clk); n = 1;
    @(negedge clk);
    in_valid9 = 1'b0;
    while (!out_valid9 && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    checks++;
    if (n !== e.lat || bin_out9 !== e.bin || err_digit9 !== e.ed || err_range9 !== e.er) begin
      errors++;
      $display("FAIL max99: got lat=%0d bin=%0d ed=%b er=%b, required lat=%0d bin=%0d ed=%b er=%b",
               n, bin_out9, err_digit9, err_range9, e.lat, e.bin, e.ed, e.er);
    end
  endtask

  task automatic test_backpressure();
    bit hold_bad = 1'b0;
    out_ready = 1'b0;
    send(8'h37);
    collect("bp37");
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      bcd_in   = 8'h11;
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || bin_out !== 7'd37 ||
          err_digit !== 1'b0 || err_range !== 1'b0) hold_bad = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (hold_bad) begin
      errors++; $display("FAIL bp_hold: got output change while stalled, required stable 37");
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || bin_out !== 7'd37) begin
      errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b bin=%0d, required 0 1 37", out_valid, in_ready, bin_out);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL bp_queue: got %0d leftover entries, required 0", sb.size());
    end
  endtask

  task automatic test_mid_reset();
    send(8'h77);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== 7'd0 ||
        err_digit !== 1'b0 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b vld=%b bin=%0d ed=%b er=%b, required 1 0 0 0 0",
               in_ready, out_valid, bin_out, err_digit, err_range);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h42); collect("after_reset42");
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    bcd_in     = 8'h00;
    in_valid9  = 1'b0;
    out_ready9 = 1'b1;
    bcd_in9    = 8'h00;
    repeat (3) @(posedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_digit_err();
    test_range();
    test_backpressure();
    send(8'h60); collect("pre_reset60");
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, required completion");
    $fatal(1);
  end

endmodule
